// File: rtl/legv8_data_memory.sv
// legv8_data_memory: doubleword-organised, byte-addressed data memory for the
// LEGv8 pipelined core. It serves one MEM-stage request per cycle with
// combinational read data and one-edge write commit. It also keeps a per-word
// valid bitmap, a sticky fault record and saturating read/write counters.
//
// Optional feature macro: LEGV8_DM_ALIGN_CHECK_EN
//   defined     - addresses with address_DM[2:0] != 0 fault and are suppressed
//   not defined - the low three address bits are ignored; only out-of-range
//                 accesses fault
module legv8_data_memory #(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] address_DM,
  input  logic [63:0] WD_DM,
  input  logic        MemRead_DM,
  input  logic        MemWrite_DM,
  output logic [63:0] RD_DM,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [63:0] fault_addr,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  // Storage is deliberately not reset; the valid bitmap hides stale contents.
  logic [63:0]      mem [DEPTH];
  logic [DEPTH-1:0] valid;

  logic [IDX_W-1:0] idx;
  logic             out_of_range;
  logic             misaligned;
  logic             any_req;
  logic             fault_now;
  logic             rd_acc;
  logic             wr_acc;
  logic [1:0]       cause;

  // Address decode and access classification for the current request.
  always_comb begin
    idx = address_DM[IDX_W+2:3];
    // DEPTH is a power of two, so "address_DM[63:3] >= DEPTH" reduces to any
    // set bit above the word-index field. This is what prevents aliasing.
    out_of_range = |address_DM[63:IDX_W+3];
`ifdef LEGV8_DM_ALIGN_CHECK_EN
    misaligned = |address_DM[2:0];
`else
    misaligned = 1'b0;
`endif
    cause     = {out_of_range, misaligned};
    any_req   = MemRead_DM | MemWrite_DM;
    // A combined read+write cycle is one access and records a fault once.
    fault_now = any_req & (|cause);
    rd_acc    = MemRead_DM & ~(|cause);
    wr_acc    = MemWrite_DM & ~(|cause);
  end

  // Combinational read; in a combined read+write cycle this returns the
  // pre-write contents because the array only changes at the edge.
  always_comb begin
    RD_DM = 64'd0;
    if (rd_acc && valid[idx]) begin
      RD_DM = mem[idx];
    end
  end

  // Array write on accepted writes. A write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem[idx] <= WD_DM;
    end
  end

  // Valid bitmap: cleared by reset, set by each accepted write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_acc) begin
      valid[idx] <= 1'b1;
    end
  end

  // Sticky fault record: the first fault captures its address, and every
  // later fault only accumulates its cause bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault      <= 1'b0;
      fault_code <= 2'b00;
      fault_addr <= 64'd0;
    end else if (fault_now) begin
      fault      <= 1'b1;
      fault_code <= fault_code | cause;
      if (!fault) begin
        fault_addr <= address_DM;
      end
    end
  end

  // Saturating counter of accepted reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count <= 32'd0;
    end else if (rd_acc && (rd_count != CNT_MAX)) begin
      rd_count <= rd_count + 32'd1;
    end
  end

  // Saturating counter of accepted writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_count <= 32'd0;
    end else if (wr_acc && (wr_count != CNT_MAX)) begin
      wr_count <= wr_count + 32'd1;
    end
  end

endmodule
